sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-to-parallel receive stage that sits directly downstream of the 4-bit parallel-in/serial-out shifter. It samples the serial bitstream one bit per qualified cycle and aligns words on a frame-start marker. Each completed WIDTH-bit word is presented on a valid/ready output register, with one word of holding buffer. It flags overruns and mid-word resynchronisation so the consumer can detect lost or corrupted words.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1: first received bit lands in parallel_out[WIDTH-1]; 0: first bit lands in parallel_out[0]

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets the block)
- serial_in  input  1  serial data bit, sampled only when bit_valid==1
- bit_valid  input  1  qualifies serial_in for this cycle
- frame_start  input  1  marks the current qualified bit as bit 0 of a new word; ignored when bit_valid==0
- clr_err  input  1  clears the sticky overrun and resync flags
- parallel_out  output  WIDTH  assembled word; stable while out_valid==1
- out_valid  output  1  parallel_out holds an unconsumed word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- overrun  output  1  sticky: a completed word was dropped because the output register was full
- resync  output  1  sticky: frame_start arrived while a partial word was in progress

## Operation
- Reset state: all outputs 0, including parallel_out, out_valid, overrun and resync; FSM=IDLE; bit counter=0; shift register=0.
- FSM states: IDLE, SHIFT.
- IDLE: qualified bits without frame_start are discarded. When bit_valid && frame_start, the block captures the bit as bit 0, sets count=1 and moves to SHIFT.
- SHIFT: each bit_valid cycle shifts serial_in into the shift register and increments count.
  - If the captured bit is bit WIDTH-1, the completed word moves to the output stage, count returns to 0 and the FSM returns to IDLE.
  - Back-to-back words therefore require frame_start on bit 0 of each word.
- frame_start in SHIFT: the partial word is discarded, the current bit becomes bit 0 of a new word (count=1), resync is set, and the FSM stays in SHIFT.
- frame_start on the last bit of a word (count==WIDTH-1): treated as a resync. The word is not completed.
- Bit order for MSB_FIRST=1: shift left, new bit into LSB, so the first bit ends up in the MSB. For MSB_FIRST=0: shift right, new bit into MSB, so the first bit ends up in the LSB.
- Output stage with a completed word:
  - The output register is loaded if out_valid==0, or if out_valid && out_ready in the same cycle (simultaneous drain and refill). out_valid ends at 1.
  - Otherwise the new word is dropped, overrun is set, and the held word is preserved.
- Handshake: the transfer occurs on a rising edge with out_valid && out_ready. With no refill in that cycle, out_valid goes to 0 next cycle. parallel_out keeps its last value after the drain.
- clr_err clears overrun and resync. If a set condition occurs in the same cycle as clr_err, the set wins.
- bit_valid==0 cycles are stalls: no state changes except handshake and clr_err.

## Timing
- Latency: the edge that samples the last bit also loads parallel_out. out_valid is high in the following cycle.
- Minimum word period is WIDTH cycles (bit_valid held high, frame_start every WIDTH cycles). With out_ready held at 1, this runs at full throughput with no overrun.
- overrun and resync are registered and assert in the cycle after the triggering edge.
- Reset asserted mid-word or with out_valid==1: the partial word and the held word are both lost. All outputs are 0 after the reset edge.
- out_ready is ignored while out_valid==0.

## Test plan
- Reset/idle: hold rst=0 for 2 cycles with random serial_in, then release with frame_start=0 and bit_valid=1 for 8 cycles -> all outputs remain 0.
- Basic word, WIDTH=4, MSB_FIRST=1: send bits 1,0,1,1 on consecutive cycles with frame_start on the first, out_ready=1 -> parallel_out=4'b1011 and out_valid=1 one cycle after the 4th bit; out_valid drops the next cycle.
- LSB-first with stalls, MSB_FIRST=0: send bits 1,0,1,1 with bit_valid=0 gaps between them -> parallel_out=4'b1101 after the 4th qualified bit.
- Backpressure: out_ready=0, send words 4'b1011 then 4'b0110 -> parallel_out stays 4'b1011 and overrun=1. Then raise clr_err -> overrun=0. Then pulse out_ready -> out_valid=0.
- Simultaneous drain and refill: with word 4'b1011 held, assert out_ready on the same edge that completes 4'b0101 -> out_valid stays 1, parallel_out=4'b0101, overrun=0.
- Resync and reset mid-word:
  - Send 2 bits, then frame_start with bits 0,0,1,1 -> resync=1 and parallel_out=4'b0011.
  - Send 2 more bits, then assert rst=0 -> counter is cleared. The next framed word 4'b1001 is received correctly.

Source files
------------

// File: rtl/sipo_rx.sv
// sipo_rx: frame-aligned serial-to-parallel receiver with valid/ready word output
module sipo_rx #(
  parameter int unsigned WIDTH = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             clr_err,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             resync
);
  localparam int unsigned CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, pout_q, pout_d, base, shifted;
  logic valid_q, valid_d, ov_q, ov_d, rs_q, rs_d;
  logic shift_en, done, load, set_rs;
  // Bit capture, word completion and output-stage next state
  always_comb begin
    shift_en = bit_valid && (frame_start || state_q == SHIFT);
    base     = frame_start ? '0 : sr_q;
    shifted  = MSB_FIRST ? {base[WIDTH-2:0], serial_in} : {serial_in, base[WIDTH-1:1]};
    done     = shift_en && !frame_start && cnt_q == CW'(WIDTH-1);
    set_rs   = bit_valid && frame_start && state_q == SHIFT;
    sr_d     = shift_en ? shifted : sr_q;
    cnt_d    = !shift_en ? cnt_q : frame_start ? CW'(1) : done ? '0 : cnt_q + 1'b1;
    state_d  = !shift_en ? state_q : done ? IDLE : SHIFT;
    load     = done && (!valid_q || out_ready);
    valid_d  = load || (valid_q && !out_ready);
    pout_d   = load ? sr_d : pout_q;
    ov_d     = (done && !load) || (ov_q && !clr_err);
    rs_d     = set_rs || (rs_q && !clr_err);
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ov_q    <= ov_d;
      rs_q    <= rs_d;
    end
  end
  assign parallel_out = pout_q;
  assign out_valid    = valid_q;
  assign overrun      = ov_q;
  assign resync       = rs_q;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed and random checks of MSB- and LSB-first receivers against a bit-queue model
module tb_sipo_rx;
  localparam int W = 4;
  logic clk = 0, rst = 0, serial_in = 0, bit_valid = 0, frame_start = 0, clr_err = 0, out_ready = 0;
  logic [W-1:0] po_m, po_l;
  logic v_m, v_l, ov_m, ov_l, rs_m, rs_l;
  int nvec = 0, nerr = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .clr_err(clr_err), .parallel_out(po_m), .out_valid(v_m), .out_ready(out_ready),
    .overrun(ov_m), .resync(rs_m));
  sipo_rx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .clr_err(clr_err), .parallel_out(po_l), .out_valid(v_l), .out_ready(out_ready),
    .overrun(ov_l), .resync(rs_l));

  // Model: the bits of the word in progress are kept in arrival order; a word is
  // built from them only when W bits have arrived since the last frame_start.
  bit q[$];
  logic [W-1:0] m_wm, m_wl, nm, nl;
  logic m_v, m_ov, m_rs;
  bit done;
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_wm = '0; m_wl = '0; m_v = 0; m_ov = 0; m_rs = 0;
    end else begin
      done = 0;
      if (clr_err) begin m_ov = 0; m_rs = 0; end
      if (bit_valid) begin
        if (frame_start) begin
          if (q.size() > 0) m_rs = 1;
          q.delete();
          q.push_back(serial_in);
        end else if (q.size() > 0) begin
          q.push_back(serial_in);
          if (q.size() == W) begin
            done = 1;
            for (int i = 0; i < W; i++) begin
              nm[W-1-i] = q[i];
              nl[i] = q[i];
            end
            q.delete();
          end
        end
      end
      if (m_v && out_ready) m_v = 0;
      if (done) begin
        if (!m_v) begin m_v = 1; m_wm = nm; m_wl = nl; end
        else m_ov = 1;
      end
    end
  end

  task automatic cmp(string n, logic [W-1:0] a, logic [W-1:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
    end
  endtask

  task automatic lit(string n, logic [W-1:0] d, logic [W-1:0] m, logic [W-1:0] e);
    cmp({n, "_dut"}, d, e);
    cmp({n, "_model"}, m, e);
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) if (chk_en) begin
    cmp("pout_msb", po_m, m_wm);
    cmp("pout_lsb", po_l, m_wl);
    cmp("valid_msb", {3'b0, v_m}, {3'b0, m_v});
    cmp("valid_lsb", {3'b0, v_l}, {3'b0, m_v});
    cmp("overrun_msb", {3'b0, ov_m}, {3'b0, m_ov});
    cmp("overrun_lsb", {3'b0, ov_l}, {3'b0, m_ov});
    cmp("resync_msb", {3'b0, rs_m}, {3'b0, m_rs});
    cmp("resync_lsb", {3'b0, rs_l}, {3'b0, m_rs});
  end

  task automatic step(input logic v, input logic s, input logic f, input logic rd,
                      input logic cl = 0, input logic r = 1);
    @(negedge clk);
    bit_valid = v; serial_in = s; frame_start = f; out_ready = rd; clr_err = cl; rst = r;
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 1'($urandom % 2), 0, 0, 0, 0);
    step(1, 1'($urandom % 2), 0, 0, 0, 0);
    chk_en = 1;
    for (int i = 0; i < 8; i++) step(1, 1'($urandom % 2), 0, 0);
    settle;
    lit("idle_pout", po_m, m_wm, 4'b0000);
    lit("idle_valid", {3'b0, v_m}, {3'b0, m_v}, 4'b0);

    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    settle;
    lit("basic_msb", po_m, m_wm, 4'b1011);
    lit("basic_lsb", po_l, m_wl, 4'b1101);
    lit("basic_valid", {3'b0, v_m}, {3'b0, m_v}, 4'b1);
    step(0, 0, 0, 1);
    settle;
    lit("basic_drain", {3'b0, v_m}, {3'b0, m_v}, 4'b0);

    step(1, 1, 1, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(0, 0, 0, 0); step(1, 1, 0, 0);
    settle;
    lit("stall_lsb", po_l, m_wl, 4'b1101);
    lit("stall_msb", po_m, m_wm, 4'b1011);

    step(1, 0, 1, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    settle;
    lit("bp_hold", po_m, m_wm, 4'b1011);
    lit("bp_overrun", {3'b0, ov_m}, {3'b0, m_ov}, 4'b1);
    step(0, 0, 0, 0, 1);
    settle;
    lit("bp_clr", {3'b0, ov_m}, {3'b0, m_ov}, 4'b0);
    step(0, 0, 0, 1);
    settle;
    lit("bp_drain", {3'b0, v_m}, {3'b0, m_v}, 4'b0);

    step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 0, 1, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    settle;
    lit("refill_valid", {3'b0, v_m}, {3'b0, m_v}, 4'b1);
    lit("refill_msb", po_m, m_wm, 4'b0101);
    lit("refill_lsb", po_l, m_wl, 4'b1010);
    lit("refill_ov", {3'b0, ov_m}, {3'b0, m_ov}, 4'b0);
    step(0, 0, 0, 1);

    step(1, 1, 1, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    settle;
    lit("resync_flag", {3'b0, rs_m}, {3'b0, m_rs}, 4'b1);
    lit("resync_msb", po_m, m_wm, 4'b0011);
    lit("resync_lsb", po_l, m_wl, 4'b1100);
    step(0, 0, 0, 1, 1);

    step(1, 1, 1, 1); step(1, 0, 0, 1); step(0, 0, 0, 1, 0, 0);
    settle;
    lit("rst_pout", po_m, m_wm, 4'b0000);
    lit("rst_valid", {3'b0, v_m}, {3'b0, m_v}, 4'b0);
    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    settle;
    lit("post_rst_msb", po_m, m_wm, 4'b1001);
    lit("post_rst_lsb", po_l, m_wl, 4'b1001);

    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    settle;
    lit("last_bit_resync", {3'b0, rs_m}, {3'b0, m_rs}, 4'b1);
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1, 1);
    for (int w = 0; w < 6; w++)
      for (int i = 0; i < W; i++) step(1, 1'($urandom % 2), i == 0, 1);
    settle;
    lit("thru_ov", {3'b0, ov_m}, {3'b0, m_ov}, 4'b0);

    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom % 2), $urandom_range(0, 4) == 0,
           1'($urandom % 2), $urandom_range(0, 9) == 0);
    step(0, 0, 0, 1);
    settle;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
